// File: rtl/sprite_line_engine_if.sv
// Host bus, video timing and status signals of the sprite line engine.
// master: host / video timing side, slave: sprite_line_engine.
interface sprite_line_engine_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic              host_we;
    logic              host_re;
    logic [7:0]        host_rdata;
    logic              host_rvalid;
    logic              vsync;
    logic              line_req;
    logic [7:0]        line_y;
    logic [7:0]        rd_x;
    logic              pixel_on;
    logic              busy;
    logic              user_interrupt;

    modport master (
        output host_addr, host_wdata, host_we, host_re, vsync, line_req, line_y, rd_x,
        input  host_rdata, host_rvalid, pixel_on, busy, user_interrupt
    );

    modport slave (
        input  host_addr, host_wdata, host_we, host_re, vsync, line_req, line_y, rd_x,
        output host_rdata, host_rvalid, pixel_on, busy, user_interrupt
    );
endinterface

// File: rtl/sprite_line_engine.sv
// Sprite line engine: staging/active object tables, 1bpp bitmap store and a
// ping-pong line buffer. Each line is rendered into the back buffer while the
// front buffer is displayed.
// Optional collision detection is built when SPRITE_COLLISION_EN is defined.
//
// state  | meaning
// IDLE   | waiting for line_req; pending table commits happen here
// CLEAR  | zero the back buffer, restart at sprite 0
// TEST   | check whether sprite spr covers the current line
// DRAW   | plot one column of sprite spr per cycle
module sprite_line_engine #(
    parameter int MAX_SPRITES  = 16,
    parameter int LINE_W       = 256,
    parameter int BITMAP_BYTES = 256,
    parameter int ADDR_W       = 10
) (
    input logic                 clk,
    input logic                 rst_n,
    sprite_line_engine_if.slave bus
);
    localparam int OBJ_BYTES = 4 * MAX_SPRITES;
    localparam int OBJ_AW    = $clog2(OBJ_BYTES);
    localparam int SPR_W     = $clog2(MAX_SPRITES);
    localparam int BMP_AW    = $clog2(BITMAP_BYTES);
    localparam int LW_AW     = $clog2(LINE_W);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_TEST, S_DRAW} state_t;

    state_t            state, state_nxt;
    logic [7:0]        stg [OBJ_BYTES];
    logic [7:0]        act [OBJ_BYTES];
    logic [7:0]        bmp [BITMAP_BYTES];
    logic [LINE_W-1:0] lbuf [2];
    logic              front_sel, back_sel;
    logic [7:0]        cur_y;
    logic [SPR_W-1:0]  spr;
    logic [3:0]        col;
    logic              bmp_we, stg_ready, overrun, collision, commit_pend, vsync_q;
    logic              vs_rise, vs_irq, coll_hit;

    logic              in_obj, in_bmp, in_ctrl;
    logic [OBJ_AW-1:0] obj_idx, ent;
    logic [BMP_AW-1:0] bmp_idx;
    logic [7:0]        rd_mux;
    logic [7:0]        spr_x, spr_y, spr_off, spr_size, row;
    logic [4:0]        w, h;
    logic [8:0]        bit_idx, byte_idx, px;
    logic              row_hit, src_bit, px_in, draw_set, last_spr, col_last;

    assign back_sel = ~front_sel;
    assign bus.busy = (state != S_IDLE);
    assign vs_rise  = bus.vsync & ~vsync_q;
    assign vs_irq   = vs_rise & ~stg_ready;

    // Host address decode and read-data mux (OBJ reads see the active table).
    always_comb begin
        in_obj  = int'(bus.host_addr) < OBJ_BYTES;
        in_bmp  = !in_obj && (int'(bus.host_addr) < OBJ_BYTES + BITMAP_BYTES);
        in_ctrl = &bus.host_addr;
        obj_idx = bus.host_addr[OBJ_AW-1:0];
        bmp_idx = BMP_AW'(bus.host_addr - ADDR_W'(OBJ_BYTES));
        rd_mux  = 8'h00;
        if (in_obj)       rd_mux = act[obj_idx];
        else if (in_bmp)  rd_mux = bmp[bmp_idx];
        else if (in_ctrl) rd_mux = {4'b0000, collision, overrun, stg_ready, bmp_we};
    end

    // Current sprite decode: row hit, bitmap bit for this column, target pixel.
    always_comb begin
        ent      = OBJ_AW'({spr, 2'b00});
        spr_x    = act[ent];
        spr_y    = act[ent + OBJ_AW'(1)];
        spr_off  = act[ent + OBJ_AW'(2)];
        spr_size = act[ent + OBJ_AW'(3)];
        w        = {1'b0, spr_size[7:4]} + 5'd1;
        h        = {1'b0, spr_size[3:0]} + 5'd1;
        row_hit  = ({1'b0, cur_y} >= {1'b0, spr_y}) && ({1'b0, cur_y} < (9'(spr_y) + 9'(h)));
        row      = cur_y - spr_y;
        bit_idx  = 9'(row) * 9'(w) + 9'(col);
        byte_idx = 9'(spr_off) + 9'(bit_idx[8:3]);
        src_bit  = (int'(byte_idx) < BITMAP_BYTES) ? bmp[byte_idx[BMP_AW-1:0]][bit_idx[2:0]] : 1'b0;
        px       = 9'(spr_x) + 9'(col);
        px_in    = int'(px) < LINE_W;
        draw_set = (state == S_DRAW) && src_bit && px_in;
        last_spr = (spr == SPR_W'(MAX_SPRITES - 1));
        col_last = ({1'b0, col} == (w - 5'd1));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.line_req) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_TEST;
            S_TEST:  if (row_hit) state_nxt = S_DRAW;
                     else if (last_spr) state_nxt = S_IDLE;
            S_DRAW:  if (col_last) state_nxt = last_spr ? S_IDLE : S_TEST;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Renderer datapath: buffer swap, sprite/column counters, back-buffer writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_sel <= 1'b0;
            cur_y     <= 8'h00;
            spr       <= '0;
            col       <= '0;
            lbuf[0]   <= '0;
            lbuf[1]   <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.line_req) begin
                    front_sel <= ~front_sel;
                    cur_y     <= bus.line_y;
                end
                S_CLEAR: begin
                    lbuf[back_sel] <= '0;
                    spr            <= '0;
                end
                S_TEST: begin
                    col <= '0;
                    if (!row_hit) spr <= spr + 1'b1;
                end
                S_DRAW: begin
                    if (draw_set) lbuf[back_sel][px[LW_AW-1:0]] <= 1'b1;
                    col <= col + 1'b1;
                    if (col_last) spr <= spr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Display read from the front buffer only; 1-cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.pixel_on <= 1'b0;
        else
            bus.pixel_on <= (int'(bus.rd_x) < LINE_W) ? lbuf[front_sel][bus.rd_x[LW_AW-1:0]] : 1'b0;
    end

    // Host register file, vsync handling and table commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OBJ_BYTES; i++) begin
                stg[i] <= 8'h00;
                act[i] <= 8'h00;
            end
            for (int i = 0; i < BITMAP_BYTES; i++) bmp[i] <= 8'h00;
            bmp_we             <= 1'b0;
            stg_ready          <= 1'b0;
            overrun            <= 1'b0;
            commit_pend        <= 1'b0;
            vsync_q            <= 1'b0;
            bus.host_rdata     <= 8'h00;
            bus.host_rvalid    <= 1'b0;
            bus.user_interrupt <= 1'b0;
        end else begin
            vsync_q            <= bus.vsync;
            bus.host_rvalid    <= bus.host_re;
            bus.user_interrupt <= vs_irq | coll_hit;
            if (bus.host_re) bus.host_rdata <= rd_mux;
            if (state == S_IDLE && commit_pend) begin
                for (int i = 0; i < OBJ_BYTES; i++) act[i] <= stg[i];
                stg_ready   <= 1'b0;
                commit_pend <= 1'b0;
            end
            if (vs_rise && stg_ready) commit_pend <= 1'b1;
            // A host CTRL write lands after the commit clear, and an overrun
            // set wins over a same-cycle write-1-to-clear.
            if (bus.host_we) begin
                if (in_obj)           stg[obj_idx] <= bus.host_wdata;
                if (in_bmp && bmp_we) bmp[bmp_idx] <= bus.host_wdata;
                if (in_ctrl) begin
                    bmp_we    <= bus.host_wdata[0];
                    stg_ready <= bus.host_wdata[1];
                    if (bus.host_wdata[2]) overrun <= 1'b0;
                end
            end
            if (bus.line_req && state != S_IDLE) overrun <= 1'b1;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic back_bit;
    assign back_bit = lbuf[back_sel][px[LW_AW-1:0]];
    assign coll_hit = draw_set & back_bit;

    // Sticky collision flag, write-1-to-clear; a new hit wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                             collision <= 1'b0;
        else if (coll_hit)                                      collision <= 1'b1;
        else if (bus.host_we && in_ctrl && bus.host_wdata[3])   collision <= 1'b0;
    end
`else
    assign coll_hit  = 1'b0;
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_line_engine.sv
// Self-checking bench for sprite_line_engine: directed steps plus randomized
// sprite tables and bitmaps, compared against a per-line behavioural model.
`timescale 1ns/1ps
module tb_sprite_line_engine;
    localparam int MAX_SPRITES  = 16;
    localparam int LINE_W       = 256;
    localparam int BITMAP_BYTES = 256;
    localparam int ADDR_W       = 10;
    localparam int OBJ_BYTES    = 4 * MAX_SPRITES;
    localparam int CTRL         = 2 ** ADDR_W - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sprite_line_engine_if #(.ADDR_W(ADDR_W)) bus ();

    sprite_line_engine #(
        .MAX_SPRITES(MAX_SPRITES), .LINE_W(LINE_W),
        .BITMAP_BYTES(BITMAP_BYTES), .ADDR_W(ADDR_W)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    int irq_seen = 0;
    int m_hits = 0;

    byte unsigned m_stg [OBJ_BYTES];
    byte unsigned m_act [OBJ_BYTES];
    byte unsigned m_bmp [BITMAP_BYTES];
    bit m_front [LINE_W];
    bit m_pend  [LINE_W];
    bit m_bmp_we, m_ready, m_ovr, m_coll;

    always @(posedge clk) if (bus.user_interrupt === 1'b1) irq_seen++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void m_reset();
        for (int i = 0; i < OBJ_BYTES; i++) begin m_stg[i] = 0; m_act[i] = 0; end
        for (int i = 0; i < BITMAP_BYTES; i++) m_bmp[i] = 0;
        for (int i = 0; i < LINE_W; i++) begin m_front[i] = 0; m_pend[i] = 0; end
        m_bmp_we = 0; m_ready = 0; m_ovr = 0; m_coll = 0;
    endfunction

    function automatic logic [7:0] exp_rd(input int a);
        if (a < OBJ_BYTES) return m_act[a];
        if (a < OBJ_BYTES + BITMAP_BYTES) return m_bmp[a - OBJ_BYTES];
        if (a == CTRL) return {4'b0000, m_coll, m_ovr, m_ready, m_bmp_we};
        return 8'h00;
    endfunction

    function automatic void m_write(input int a, input logic [7:0] d);
        if (a < OBJ_BYTES) m_stg[a] = d;
        else if (a < OBJ_BYTES + BITMAP_BYTES) begin
            if (m_bmp_we) m_bmp[a - OBJ_BYTES] = d;
        end else if (a == CTRL) begin
            m_bmp_we = d[0];
            m_ready  = d[1];
            if (d[2]) m_ovr = 0;
            if (d[3]) m_coll = 0;
        end
    endfunction

    // Whole-line reference: every sprite covering line y ORs its row into the line.
    function automatic void render(input int y);
        int x, sy, off, sz, wd, ht, b, by, px;
        for (int i = 0; i < LINE_W; i++) m_pend[i] = 0;
        m_hits = 0;
        for (int s = 0; s < MAX_SPRITES; s++) begin
            x = m_act[4*s]; sy = m_act[4*s+1]; off = m_act[4*s+2]; sz = m_act[4*s+3];
            wd = sz / 16 + 1; ht = sz % 16 + 1;
            if (y >= sy && y < sy + ht) begin
                for (int c = 0; c < wd; c++) begin
                    b = (y - sy) * wd + c; by = off + b / 8; px = x + c;
                    if (by < BITMAP_BYTES && px < LINE_W && ((m_bmp[by] >> (b % 8)) & 1) == 1) begin
                        if (m_pend[px]) m_hits++;
                        m_pend[px] = 1;
                    end
                end
            end
        end
`ifdef SPRITE_COLLISION_EN
        if (m_hits > 0) m_coll = 1;
`endif
    endfunction

    function automatic int exp_coll_irq();
`ifdef SPRITE_COLLISION_EN
        return m_hits;
`else
        return 0;
`endif
    endfunction

    task automatic wr(input int a, input int d);
        bus.host_addr = ADDR_W'(a); bus.host_wdata = 8'(d); bus.host_we = 1'b1;
        tick();
        bus.host_we = 1'b0;
        m_write(a, 8'(d));
    endtask

    task automatic rd_chk(input string tag, input int a);
        logic [7:0] e;
        e = exp_rd(a);
        bus.host_addr = ADDR_W'(a); bus.host_re = 1'b1;
        tick();
        bus.host_re = 1'b0;
        chk({tag, "_rvalid"}, bus.host_rvalid, 1);
        chk(tag, bus.host_rdata, e);
    endtask

    task automatic rw_same(input string tag, input int a, input int d);
        logic [7:0] e;
        e = exp_rd(a);
        bus.host_addr = ADDR_W'(a); bus.host_wdata = 8'(d);
        bus.host_we = 1'b1; bus.host_re = 1'b1;
        tick();
        bus.host_we = 1'b0; bus.host_re = 1'b0;
        m_write(a, 8'(d));
        chk(tag, bus.host_rdata, e);
    endtask

    task automatic vsync_pulse(output int irqs);
        int base;
        base = irq_seen;
        bus.vsync = 1'b1; repeat (3) tick();
        bus.vsync = 1'b0; repeat (3) tick();
        irqs = irq_seen - base;
        if (m_ready) begin
            for (int i = 0; i < OBJ_BYTES; i++) m_act[i] = m_stg[i];
            m_ready = 0;
        end
    endtask

    task automatic line(input int y, input bit accept);
        bus.line_y = 8'(y); bus.line_req = 1'b1;
        tick();
        bus.line_req = 1'b0;
        if (accept) begin
            m_front = m_pend;
            render(y);
        end else m_ovr = 1;
    endtask

    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (bus.busy !== 1'b0 && n < 400) begin tick(); n++; end
        chk({tag, "_idle"}, bus.busy, 0);
    endtask

    task automatic pix_chk(input string tag, input int x, input bit e);
        bus.rd_x = 8'(x);
        tick();
        chk($sformatf("%s_x%0d", tag, x), bus.pixel_on, e);
    endtask

    task automatic line_chk(input string tag);
        for (int x = 0; x < LINE_W; x++) pix_chk(tag, x, m_front[x]);
    endtask

    bit tp_exp [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0};

    initial begin
        int k, n, base;
        bus.host_addr = '0; bus.host_wdata = '0; bus.host_we = 0; bus.host_re = 0;
        bus.vsync = 0; bus.line_req = 0; bus.line_y = '0; bus.rd_x = '0;
        m_reset();
        repeat (3) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_pixel", bus.pixel_on, 0);
        chk("rst_irq", bus.user_interrupt, 0);
        chk("rst_rvalid", bus.host_rvalid, 0);
        rst_n = 1'b1;
        tick();
        rd_chk("ctrl_reset", CTRL);
        wr(500, 8'h5A);
        rd_chk("unmapped", 500);

        vsync_pulse(k);
        chk("vsync_irq_count", k, 1);

        // Test-plan sprite 0: 8x1 at (10,5), bitmap byte 0 = A5
        wr(0, 10); wr(1, 5); wr(2, 0); wr(3, 8'h70);
        rd_chk("obj_active_before_commit", 0);
        wr(OBJ_BYTES, 8'hA5);
        rd_chk("bmp_write_locked", OBJ_BYTES);
        wr(CTRL, 8'h01);
        wr(OBJ_BYTES, 8'hA5);
        rd_chk("bmp_written", OBJ_BYTES);
        rw_same("read_during_write", OBJ_BYTES + 9, 8'h3C);
        rd_chk("bmp_after_rw", OBJ_BYTES + 9);
        wr(CTRL, 8'h02);
        rd_chk("ctrl_ready", CTRL);
        vsync_pulse(k);
        chk("commit_no_irq", k, 0);
        for (int i = 0; i < 4; i++) rd_chk($sformatf("obj_committed%0d", i), i);
        rd_chk("ctrl_after_commit", CTRL);

        line(5, 1); wait_idle("tp_l5", n);
        line(0, 1);
        for (int i = 0; i < 10; i++) pix_chk("tp_a5", 9 + i, tp_exp[i]);
        wait_idle("tp_l0", n);

        // Right clip: 8 pixels from x=252, bitmap FF
        wr(4, 252); wr(5, 7); wr(6, 1); wr(7, 8'h70);
        wr(CTRL, 8'h01); wr(OBJ_BYTES + 1, 8'hFF); wr(CTRL, 8'h02);
        vsync_pulse(k);
        line(7, 1); wait_idle("clip_l7", n);
        line(0, 1);
        for (int x = 252; x < 256; x++) pix_chk("clip_on", x, 1);
        for (int x = 0; x < 4; x++) pix_chk("clip_nowrap", x, 0);
        wait_idle("clip_l0", n);

        // Randomized tables and bitmaps
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < MAX_SPRITES; s++) begin
                wr(4*s, $urandom_range(0, 255)); wr(4*s+1, $urandom_range(0, 31));
                wr(4*s+2, $urandom_range(0, 255)); wr(4*s+3, $urandom_range(0, 255));
            end
            wr(CTRL, 8'h01);
            for (int b = 0; b < BITMAP_BYTES; b++) wr(OBJ_BYTES + b, $urandom_range(0, 255));
            wr(CTRL, 8'h02);
            vsync_pulse(k);
            chk($sformatf("rand%0d_commit_irq", r), k, 0);
            for (int l = 0; l < 3; l++) begin
                base = irq_seen;
                line($urandom_range(0, 47), 1);
                line_chk($sformatf("rand%0d_%0d", r, l));
                wait_idle("rand", n);
                chk("rand_coll_irq", irq_seen - base, exp_coll_irq());
            end
            rd_chk($sformatf("rand%0d_ctrl", r), CTRL);
        end

        // Overrun: 16 sprites of 16x1 on line 10, second request 3 cycles later
        for (int s = 0; s < MAX_SPRITES; s++) begin
            wr(4*s, 16*s); wr(4*s+1, 10); wr(4*s+2, 0); wr(4*s+3, 8'hF0);
        end
        wr(CTRL, 8'h02);
        vsync_pulse(k);
        line(10, 1);
        tick(); tick();
        chk("ovr_busy", bus.busy, 1);
        line(11, 0);
        wait_idle("ovr", n);
        chk("ovr_render_budget", (n + 3) <= (2 + MAX_SPRITES * 17), 1);
        rd_chk("ovr_ctrl_set", CTRL);
        line_chk("ovr_noswap");
        wr(CTRL, 8'h04);
        rd_chk("ovr_ctrl_cleared", CTRL);
        line(0, 1);
        line_chk("ovr_render_done");
        wait_idle("ovr_l0", n);

        // Collision: two 1x1 sprites at (20,5), then moved apart
        for (int s = 0; s < MAX_SPRITES; s++) begin
            wr(4*s, 0); wr(4*s+1, 200); wr(4*s+2, 0); wr(4*s+3, 0);
        end
        wr(0, 20); wr(1, 5); wr(4, 20); wr(5, 5);
        wr(CTRL, 8'h09); wr(OBJ_BYTES, 8'h01); wr(CTRL, 8'h02);
        vsync_pulse(k);
        base = irq_seen;
        line(5, 1); wait_idle("coll", n);
        chk("coll_irq", irq_seen - base, exp_coll_irq());
        rd_chk("coll_ctrl", CTRL);
        wr(CTRL, 8'h08);
        wr(4, 30); wr(CTRL, 8'h02);
        vsync_pulse(k);
        base = irq_seen;
        line(5, 1); wait_idle("nocoll", n);
        chk("nocoll_irq", irq_seen - base, 0);
        rd_chk("nocoll_ctrl", CTRL);
        line(0, 1);
        pix_chk("coll_front", 20, m_front[20]);
        pix_chk("coll_front", 30, m_front[30]);
        wait_idle("coll_l0", n);

        // Reset in the middle of DRAW
        wr(0, 0); wr(1, 5); wr(3, 8'hFF); wr(CTRL, 8'h02);
        vsync_pulse(k);
        line(5, 1);
        repeat (4) tick();
        chk("mid_draw_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("arst_busy", bus.busy, 0);
        chk("arst_pixel", bus.pixel_on, 0);
        chk("arst_irq", bus.user_interrupt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_busy", bus.busy, 0);
        chk("rel_irq", bus.user_interrupt, 0);
        pix_chk("rel_pixel", 30, 0);
        rd_chk("rel_ctrl", CTRL);
        rd_chk("rel_obj", 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
